// File: rtl/ripple_adder.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin through an explicit
// chain of 1-bit full adders, with one-cycle latency and carry/overflow/zero flags.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign p[i]   = a[i] ^ b[i];
        assign s[i]   = p[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & p[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_valid <= in_valid;
            // NOTE: no else branch on purpose; result registers hold while idle, so
            // unknown operands presented with in_valid low never reach the outputs.
            if (in_valid) begin
                sum      <= s;
                cout     <= c[WIDTH];
                overflow <= c[WIDTH] ^ c[WIDTH-1];
                zero     <= (s == '0);
            end
        end
    end

endmodule

// File: tb/tb_ripple_adder.sv
// Directed bench for ripple_adder at WIDTH=4, 8 and 1 with hand-computed
// expected results, hold, and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_ripple_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // WIDTH=4 instance
    logic       v4, c4;
    logic [3:0] a4, b4;
    logic       ov4, co4, of4, z4;
    logic [3:0] s4;

    ripple_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .out_valid(ov4), .sum(s4), .cout(co4), .overflow(of4), .zero(z4)
    );

    // WIDTH=8 instance
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       ov8, co8, of8, z8;
    logic [7:0] s8;

    ripple_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8), .overflow(of8), .zero(z8)
    );

    // WIDTH=1 instance
    logic v1, c1;
    logic a1, b1;
    logic ov1, co1, of1, z1;
    logic s1;

    ripple_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1), .overflow(of1), .zero(z1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags checked as a packed triple {cout, overflow, zero}.
    task automatic step4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                         input logic tc, input logic [3:0] es, input logic [2:0] ef);
        v4 = 1'b1; a4 = ta; b4 = tb; c4 = tc;
        @(posedge clk); #1;
        chk({tag, " valid"}, 64'(ov4), 64'd1);
        chk({tag, " sum"},   64'(s4),  64'(es));
        chk({tag, " flags"}, 64'({co4, of4, z4}), 64'(ef));
    endtask

    task automatic step8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic [2:0] ef);
        v8 = 1'b1; a8 = ta; b8 = tb; c8 = tc;
        @(posedge clk); #1;
        chk({tag, " valid"}, 64'(ov8), 64'd1);
        chk({tag, " sum"},   64'(s8),  64'(es));
        chk({tag, " flags"}, 64'({co8, of8, z8}), 64'(ef));
    endtask

    // WIDTH=1 truth table rows: {a, b, cin, sum, cout, overflow}
    logic [5:0] w1_table [8] = '{
        6'b000_000, 6'b001_101, 6'b010_100, 6'b011_010,
        6'b100_100, 6'b101_010, 6'b110_011, 6'b111_110
    };

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset valid4", 64'(ov4), 64'd0);
        chk("reset sum4",   64'(s4),  64'd0);
        chk("reset flags4", 64'({co4, of4, z4}), 64'd0);
        chk("reset valid8", 64'(ov8), 64'd0);
        chk("reset valid1", 64'(ov1), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-release idle valid4", 64'(ov4), 64'd0);

        // Low sweep, back-to-back: a=0, b=i>>1, cin=i[0]; i=15 gives 0+7+1 = 1000,
        // a signed overflow (carry into MSB set, carry out clear).
        for (int i = 0; i < 16; i++) begin
            logic [3:0] bi;
            logic [3:0] es;
            bi = 4'(i / 2);
            es = 4'(i / 2 + i % 2);
            step4($sformatf("sweep%0d", i), 4'b0000, bi, i[0], es,
                  {1'b0, (i == 15), (i == 0)});
        end

        step4("wrap 15+1",      4'b1111, 4'b0001, 1'b0, 4'b0000, 3'b101);
        step4("wrap 15+15+1",   4'b1111, 4'b1111, 1'b1, 4'b1111, 3'b100);
        step4("ovf 7+1",        4'b0111, 4'b0001, 1'b0, 4'b1000, 3'b010);
        step4("ovf -8+-8",      4'b1000, 4'b1000, 1'b0, 4'b0000, 3'b111);
        step4("hold accept",    4'b0011, 4'b0100, 1'b1, 4'b1000, 3'b010);

        // Idle cycles with changing and unknown operands must leave results alone.
        v4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a4 = (k == 1) ? 4'bxxxx : 4'(k + 5);
            b4 = (k == 1) ? 4'bxxxx : 4'(k * 3);
            c4 = (k == 1) ? 1'bx : 1'b1;
            @(posedge clk); #1;
            chk($sformatf("hold%0d valid", k), 64'(ov4), 64'd0);
            chk($sformatf("hold%0d sum", k),   64'(s4),  64'h8);
            chk($sformatf("hold%0d flags", k), 64'({co4, of4, z4}), 64'b010);
        end

        // Asynchronous reset mid-cycle clears outputs without waiting for a clock.
        a4 = 4'b0000; b4 = 4'b0000; c4 = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async rst sum",   64'(s4), 64'd0);
        chk("async rst flags", 64'({co4, of4, z4}), 64'd0);
        @(posedge clk); #1;
        chk("rst held valid", 64'(ov4), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst release idle valid", 64'(ov4), 64'd0);

        // An operation presented in the cycle reset falls is discarded.
        v4 = 1'b1; a4 = 4'b0101; b4 = 4'b0011; c4 = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("discard valid", 64'(ov4), 64'd0);
        chk("discard sum",   64'(s4),  64'd0);
        v4 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no pulse after release", 64'(ov4), 64'd0);
        @(posedge clk); #1;
        chk("no pulse after release 2", 64'(ov4), 64'd0);
        step4("recover 5+3", 4'b0101, 4'b0011, 1'b0, 4'b1000, 3'b010);
        v4 = 1'b0;

        // WIDTH=8 directed vectors, back-to-back.
        step8("w8 ff+01",    8'hFF, 8'h01, 1'b0, 8'h00, 3'b101);
        step8("w8 7f+01",    8'h7F, 8'h01, 1'b0, 8'h80, 3'b010);
        step8("w8 80+80",    8'h80, 8'h80, 1'b0, 8'h00, 3'b111);
        step8("w8 55+aa+1",  8'h55, 8'hAA, 1'b1, 8'h00, 3'b101);
        step8("w8 12+34+1",  8'h12, 8'h34, 1'b1, 8'h47, 3'b000);
        step8("w8 c8+9c",    8'hC8, 8'h9C, 1'b0, 8'h64, 3'b110);
        v8 = 1'b0;
        @(posedge clk); #1;
        chk("w8 idle valid", 64'(ov8), 64'd0);
        chk("w8 idle sum",   64'(s8),  64'h64);

        // WIDTH=1 exhaustive truth table, back-to-back.
        for (int r = 0; r < 8; r++) begin
            logic [5:0] row;
            row = w1_table[r];
            v1 = 1'b1; a1 = row[5]; b1 = row[4]; c1 = row[3];
            @(posedge clk); #1;
            chk($sformatf("w1 row%0d valid", r), 64'(ov1), 64'd1);
            chk($sformatf("w1 row%0d sum", r),   64'(s1),  64'(row[2]));
            chk($sformatf("w1 row%0d flags", r), 64'({co1, of1, z1}),
                64'({row[1], row[0], ~row[2]}));
        end
        v1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
